// File: rtl/tdc_diff_sched.sv
// rtl/tdc_diff_sched.sv - round-robin sharing of one start/stop differencer across NCH TDC channels
// Optional watchdog/flush path is built only when TDC_WDOG_EN is defined.
module tdc_diff_sched #(
  parameter  int NCH    = 4,
  parameter  int DW     = 20,
  parameter  int TO_CYC = 64,
  localparam int CW     = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH*DW-1:0] ch_start,
  input  logic [NCH*DW-1:0] ch_stop,
  output logic [NCH-1:0]    ch_ack,
  output logic              d_dval,
  output logic [DW-1:0]     d_mlt,
  output logic              d_rst_n,
  input  logic [DW-1:0]     d_res,
  input  logic              d_res_vld,
  output logic              res_vld,
  output logic [DW-1:0]     res_data,
  output logic [CW-1:0]     res_ch,
  output logic              busy,
  output logic              err,
  output logic [CW-1:0]     err_ch
);

`ifdef TDC_WDOG_EN
  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_START, S_STOP, S_WAIT, S_FLUSH
  } state_t;
  localparam int WW = $clog2(TO_CYC + 1);
`else
  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_START, S_STOP, S_WAIT
  } state_t;
`endif

  if (NCH < 2 || NCH > 16 || TO_CYC < 4) begin : g_param_check
    $error("tdc_diff_sched: illegal parameter set");
  end

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_last;
  logic [CW-1:0]   r_tag;
  logic [DW-1:0]   r_start;
  logic [DW-1:0]   r_stop;
  logic            r_res_vld;
  logic [DW-1:0]   r_res_data;
  logic [CW-1:0]   r_res_ch;
  logic            r_d_rst_n;
  logic            w_found;
  logic [CW-1:0]   w_pick;
  logic [CW-1:0]   w_cand;
  logic            w_timeout;

`ifdef TDC_WDOG_EN
  logic [WW-1:0]   r_wdog;
  logic            r_fcnt;
  logic [CW-1:0]   r_err_ch;
`endif

  // Walk the channels starting just after the last grant, wrapping at NCH-1.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = r_last;
    for (int k = 0; k < NCH; k++) begin
      w_cand = (w_cand == CW'(NCH - 1)) ? '0 : w_cand + CW'(1);
      if (!w_found && ch_req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

`ifdef TDC_WDOG_EN
  assign w_timeout = (r_wdog == WW'(TO_CYC - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next = S_GRANT;
      S_GRANT: w_next = S_START;
      S_START: w_next = S_STOP;
      S_STOP:  w_next = S_WAIT;
      S_WAIT: begin
        if (d_res_vld) begin
          w_next = S_IDLE;
        end
`ifdef TDC_WDOG_EN
        else if (w_timeout) begin
          w_next = S_FLUSH;
        end
`endif
      end
`ifdef TDC_WDOG_EN
      S_FLUSH: if (r_fcnt) w_next = S_IDLE;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ch_ack = '0;
    d_dval = 1'b0;
    d_mlt  = '0;
    busy   = (r_state != S_IDLE);
    case (r_state)
      S_GRANT: ch_ack = NCH'(1) << r_tag;
      S_START: begin
        d_dval = 1'b1;
        d_mlt  = r_start;
      end
      S_STOP: begin
        d_dval = 1'b1;
        d_mlt  = r_stop;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last     <= CW'(NCH - 1);
      r_tag      <= '0;
      r_start    <= '0;
      r_stop     <= '0;
      r_res_vld  <= 1'b0;
      r_res_data <= '0;
      r_res_ch   <= '0;
      r_d_rst_n  <= 1'b0;
    end else begin
`ifdef TDC_WDOG_EN
      // Differencer reset follows FLUSH occupancy one edge ahead, so it is low for both FLUSH cycles.
      r_d_rst_n <= (w_next != S_FLUSH);
`else
      r_d_rst_n <= 1'b1;
`endif
      r_res_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_tag  <= w_pick;
            r_last <= w_pick;
          end
        end
        S_GRANT: begin
          r_start <= ch_start[r_tag*DW +: DW];
          r_stop  <= ch_stop[r_tag*DW +: DW];
        end
        S_WAIT: begin
          if (d_res_vld) begin
            r_res_vld  <= 1'b1;
            r_res_data <= d_res;
            r_res_ch   <= r_tag;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TDC_WDOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog   <= '0;
      r_fcnt   <= 1'b0;
      r_err_ch <= '0;
    end else begin
      case (r_state)
        S_STOP: r_wdog <= '0;
        S_WAIT: begin
          r_wdog <= r_wdog + WW'(1);
          if (!d_res_vld && w_timeout) begin
            r_err_ch <= r_tag;
            r_fcnt   <= 1'b0;
          end
        end
        S_FLUSH: r_fcnt <= 1'b1;
        default: ;
      endcase
    end
  end

  assign err    = (r_state == S_FLUSH) && !r_fcnt;
  assign err_ch = r_err_ch;
`else
  assign err    = 1'b0;
  assign err_ch = '0;
`endif

  assign d_rst_n  = r_d_rst_n;
  assign res_vld  = r_res_vld;
  assign res_data = r_res_data;
  assign res_ch   = r_res_ch;

endmodule

// File: tb/tb_tdc_diff_sched.sv
// tb/tb_tdc_diff_sched.sv - bench for tdc_diff_sched: table vectors, corner sequences, random traffic
// Watchdog sequences are included when TDC_WDOG_EN is defined.
module tb_tdc_diff_sched;
  localparam int NCH    = 4;
  localparam int DW     = 20;
  localparam int TO_CYC = 64;
  localparam int CW     = $clog2(NCH);

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    ch_req;
  logic [NCH*DW-1:0] ch_start;
  logic [NCH*DW-1:0] ch_stop;
  logic [NCH-1:0]    ch_ack;
  logic              d_dval;
  logic [DW-1:0]     d_mlt;
  logic              d_rst_n;
  logic [DW-1:0]     d_res;
  logic              d_res_vld;
  logic              res_vld;
  logic [DW-1:0]     res_data;
  logic [CW-1:0]     res_ch;
  logic              busy;
  logic              err;
  logic [CW-1:0]     err_ch;

  always #5 clk = ~clk;

  tdc_diff_sched #(.NCH(NCH), .DW(DW), .TO_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst), .ch_req(ch_req), .ch_start(ch_start), .ch_stop(ch_stop),
    .ch_ack(ch_ack), .d_dval(d_dval), .d_mlt(d_mlt), .d_rst_n(d_rst_n),
    .d_res(d_res), .d_res_vld(d_res_vld), .res_vld(res_vld), .res_data(res_data),
    .res_ch(res_ch), .busy(busy), .err(err), .err_ch(err_ch)
  );

  typedef struct {
    logic [NCH-1:0] mask;
    logic [DW-1:0]  st;
    logic [DW-1:0]  sp;
    logic [DW-1:0]  res;
    int             lat;
    int             ch;
  } vec_t;

  vec_t          tbl[14];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            rr_last = NCH - 1;
  logic [DW-1:0] st_v[NCH];
  logic [DW-1:0] sp_v[NCH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_pick(input logic [NCH-1:0] mask);
    for (int k = 1; k <= NCH; k++) begin
      if (mask[(rr_last + k) % NCH]) return (rr_last + k) % NCH;
    end
    return -1;
  endfunction

  task automatic load_ts();
    for (int i = 0; i < NCH; i++) begin
      ch_start[i*DW +: DW] = st_v[i];
      ch_stop[i*DW +: DW]  = sp_v[i];
    end
  endtask

  task automatic rand_ts();
    for (int i = 0; i < NCH; i++) begin
      st_v[i] = DW'($urandom);
      sp_v[i] = DW'($urandom);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the STOP cycle.
  task automatic do_grant(input logic [NCH-1:0] mask, input int exp_ch);
    int n;
    load_ts();
    ch_req = mask;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ch_ack == '0 && n < 20);
    chk("ack_onehot", 32'(ch_ack), 32'(1) << exp_ch);
    chk("ack_latency", n, 1);
    ch_req  = '0;
    rr_last = exp_ch;
    @(negedge clk);
    chk("ack_one_cycle", 32'(ch_ack), 0);
    chk("dval_start", 32'(d_dval), 1);
    chk("mlt_start", 32'(d_mlt), 32'(st_v[exp_ch]));
    @(negedge clk);
    chk("dval_stop", 32'(d_dval), 1);
    chk("mlt_stop", 32'(d_mlt), 32'(sp_v[exp_ch]));
  endtask

  // Differencer answers during cycle STOP+lat; result checked the cycle after.
  task automatic do_result(input int lat, input logic [DW-1:0] val, input int exp_ch);
    logic seen_err;
    logic seen_dv;
    logic seen_rv;
    seen_err = 1'b0;
    seen_dv  = 1'b0;
    seen_rv  = 1'b0;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      if (err) seen_err = 1'b1;
      if (d_dval || d_mlt != '0) seen_dv = 1'b1;
      if (res_vld) seen_rv = 1'b1;
    end
    chk("busy_wait", 32'(busy), 1);
    chk("quiet_wait", 32'({seen_dv, seen_rv}), 0);
    d_res     = val;
    d_res_vld = 1'b1;
    @(negedge clk);
    d_res_vld = 1'b0;
    d_res     = DW'($urandom);
    chk("res_vld", 32'(res_vld), 1);
    chk("res_data", 32'(res_data), 32'(val));
    chk("res_ch", 32'(res_ch), exp_ch);
    chk("idle_after_res", 32'(busy), 0);
    chk("no_err", 32'({seen_err, err}), 0);
    @(negedge clk);
    chk("res_vld_pulse", 32'(res_vld), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    int c;
    logic [NCH-1:0] m;

    tbl[0]  = '{4'b1111, 20'h0A001, 20'h0A0F0, 20'h11111, 2, 1};
    tbl[1]  = '{4'b1111, 20'h0B002, 20'h0B1F0, 20'h22222, 1, 2};
    tbl[2]  = '{4'b1111, 20'hFFFFF, 20'h00000, 20'hFFFFF, 5, 3};
    tbl[3]  = '{4'b1010, 20'h00001, 20'h00002, 20'h00000, 3, 1};
    tbl[4]  = '{4'b1010, 20'h12345, 20'h6789A, 20'hABCDE, 4, 3};
    tbl[5]  = '{4'b1111, 20'h55555, 20'hAAAAA, 20'h80000, 1, 0};
    tbl[6]  = '{4'b1111, 20'h00010, 20'h00020, 20'h00001, 7, 1};
    tbl[7]  = '{4'b0101, 20'h3C3C3, 20'hC3C3C, 20'h7FFFF, 2, 2};
    tbl[8]  = '{4'b1001, 20'h00100, 20'h00250, 20'h00950, 3, 3};
    tbl[9]  = '{4'b0011, 20'h0F0F0, 20'hF0F0F, 20'h0BEEF, 6, 0};
    tbl[10] = '{4'b1100, 20'h11223, 20'h33445, 20'h55667, 2, 2};
    tbl[11] = '{4'b0110, 20'h99999, 20'h88888, 20'h77777, 1, 1};
    tbl[12] = '{4'b1000, 20'h00ABC, 20'h00DEF, 20'h01234, 3, 3};
    tbl[13] = '{4'b1111, 20'hDEAD0, 20'hBEEF0, 20'hCAFE0, 2, 0};

    rst       = 1'b1;
    ch_req    = '0;
    ch_start  = '0;
    ch_stop   = '0;
    d_res     = '0;
    d_res_vld = 1'b0;
    rand_ts();
    repeat (2) @(negedge clk);
    chk("rst_ch_ack", 32'(ch_ack), 0);
    chk("rst_d_dval", 32'(d_dval), 0);
    chk("rst_d_mlt", 32'(d_mlt), 0);
    chk("rst_d_rst_n", 32'(d_rst_n), 0);
    chk("rst_res", 32'({res_vld, res_ch, res_data}), 0);
    chk("rst_busy_err", 32'({busy, err, err_ch}), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("d_rst_n_release", 32'(d_rst_n), 1);

    // Single ch0 request with the reference timestamps.
    st_v[0] = 20'h00100;
    sp_v[0] = 20'h00250;
    do_grant(4'b0001, 0);
    do_result(3, 20'h00950, 0);

    // Stray differencer strobe while idle.
    d_res     = 20'h0DEAD;
    d_res_vld = 1'b1;
    @(negedge clk);
    d_res_vld = 1'b0;
    chk("idle_strobe_res_vld", 32'(res_vld), 0);
    chk("idle_strobe_busy", 32'(busy), 0);
    @(negedge clk);
    chk("idle_strobe_hold", 32'({res_vld, res_data}), 32'(20'h00950));

    // Reset asserted during STOP.
    rand_ts();
    load_ts();
    ch_req = 4'b0010;
    @(negedge clk);
    ch_req = '0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_dval", 32'(d_dval), 1);
    rst = 1'b1;
    #1;
    chk("midrst_dval_mlt", 32'({d_dval, d_mlt}), 0);
    chk("midrst_ack_busy", 32'({ch_ack, busy}), 0);
    chk("midrst_d_rst_n", 32'(d_rst_n), 0);
    @(negedge clk);
    rst     = 1'b0;
    rr_last = NCH - 1;
    @(negedge clk);
    chk("post_rst_d_rst_n", 32'(d_rst_n), 1);
    chk("post_rst_idle", 32'(busy), 0);
    rand_ts();
    do_grant(4'b1111, 0);
    do_result(2, 20'h0C0DE, 0);

    for (int i = 0; i < 14; i++) begin
      rand_ts();
      st_v[tbl[i].ch] = tbl[i].st;
      sp_v[tbl[i].ch] = tbl[i].sp;
      do_grant(tbl[i].mask, tbl[i].ch);
      do_result(tbl[i].lat, tbl[i].res, tbl[i].ch);
    end

`ifdef TDC_WDOG_EN
    // Channel 2 granted, differencer never answers.
    rand_ts();
    do_grant(4'b0100, 2);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!err && n < 100);
    chk("wdog_err_latency", n, 65);
    chk("wdog_err_ch", 32'(err_ch), 2);
    chk("flush1_d_rst_n", 32'(d_rst_n), 0);
    chk("flush1_busy", 32'(busy), 1);
    @(negedge clk);
    chk("flush2_err_off", 32'(err), 0);
    chk("flush2_d_rst_n", 32'(d_rst_n), 0);
    @(negedge clk);
    chk("flush_done_d_rst_n", 32'(d_rst_n), 1);
    chk("flush_done_idle", 32'(busy), 0);
    rand_ts();
    do_grant(4'b0001, 0);
    do_result(3, 20'h13579, 0);

    // Result lands in the terminal WAIT cycle: it wins over the watchdog.
    rand_ts();
    do_grant(4'b1000, 3);
    do_result(TO_CYC, 20'h2468A, 3);
`endif

    for (int i = 0; i < 40; i++) begin
      m = NCH'($urandom_range(1, (1 << NCH) - 1));
      c = model_pick(m);
      rand_ts();
      do_grant(m, c);
      do_result($urandom_range(1, 8), DW'($urandom), c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
